t05_stage_sequencer: RTL
========================

// Module: t05_stage_sequencer
// PURPOSE
// Parametrised top-level sequencer for the Huffman compression pipeline.
// Walks NUM_STAGES stages in order (default HISTO,FLV,HTREE,CBS,TRN,SPI).
// Supports one programmable loop-back edge (HTREE->FLV) with an iteration cap,
// a per-stage watchdog, error capture and abort. Sits above all stage modules.
// PARAMETERS
// NUM_STAGES   6   number of pipeline stages, 1..13
// STATE_W      4   state encoding width, must satisfy 2**STATE_W >= NUM_STAGES+3
// TIMEOUT_W    16  watchdog counter and limit width
// LOOP_SRC     3   stage number that may request loop-back (HTREE)
// LOOP_DST     2   stage number re-entered on loop-back (FLV), LOOP_DST <= LOOP_SRC
// MAX_LOOPS    255 loop-back cap; must be < 2**LOOP_W
// LOOP_W       8   loop counter width
// PORTS
// clk            in   1           clock
// rst            in   1           synchronous active-high reset
// start          in   1           begin run; honoured only in IDLE
// restart        in   1           abort/clear: any non-IDLE state -> IDLE
// timeout_limit  in   TIMEOUT_W   watchdog cycles per stage; 0 = disabled
// stage_done     in   NUM_STAGES  bit k-1: stage k finished (level or pulse)
// stage_loop     in   NUM_STAGES  bit k-1: with done, stage k requests loop-back
// stage_err      in   NUM_STAGES  bit k-1: stage k error
// state_reg      out  STATE_W     0=IDLE, k=stage k, NUM_STAGES+1=ERROR, NUM_STAGES+2=DONE
// stage_start    out  NUM_STAGES  one-cycle pulse on the first cycle in stage k
// finished       out  1           high while in DONE
// error          out  1           high while in ERROR
// err_stage      out  STATE_W     stage that faulted; 0 if no fault
// err_code       out  2           0 none, 1 stage error, 2 timeout, 3 loop overflow
// loop_count     out  LOOP_W      loop-backs taken this run
// perf_sel       in   STATE_W     stage to read (T05_SEQ_PERF_EN only)
// perf_cycles    out  32          cycles spent in perf_sel, summed over re-entries
// BEHAVIOUR
// - All outputs registered. Reset: state IDLE, every output 0, counters 0.
// - Reset applied mid-run has the same effect as reset at power-up.
// - IDLE: start -> stage 1 on the next edge; loop_count, err_* and watchdog cleared.
// - Stage k, priorities per cycle (highest first):
//   restart > stage_err[k-1] > stage_done[k-1] > watchdog.
// - stage_err[k-1]: go to ERROR, err_code=1, err_stage=k.
// - stage_done[k-1] with k==LOOP_SRC and stage_loop[k-1]:
//   - if loop_count==MAX_LOOPS: go to ERROR, err_code=3.
//   - else: go to LOOP_DST and increment loop_count.
// - stage_done[k-1], no loop request: go to k+1; k==NUM_STAGES goes to DONE.
// - Watchdog counts cycles in the current stage and clears on each stage entry.
//   - If timeout_limit!=0 and the count reaches timeout_limit-1 with no done:
//     go to ERROR, err_code=2.
//   - A stage may therefore occupy at most timeout_limit cycles.
// - Inputs from non-current stages are ignored: done, loop and err bits.
//   stage_loop is ignored when k!=LOOP_SRC.
// - Latency: done seen at edge N; state_reg and stage_start of the next stage
//   are valid after edge N. A stage lasts at least 1 cycle.
// - stage_start[j-1] pulses exactly once per entry into stage j, including loop re-entries.
// - DONE: finished=1. Leaves only on restart -> IDLE; start is ignored.
// - ERROR: error=1; err_stage and err_code held. Leaves only on restart -> IDLE,
//   which clears them.
// - restart in IDLE: no effect. start and restart together in IDLE: restart wins, stay IDLE.
// - Illegal state encoding: go to ERROR, err_code=1, err_stage=0.
// CONFIGURATION
// T05_SEQ_PERF_EN defined:
//   - One 32-bit saturating cycle counter per stage; adds 1 each cycle in that stage.
//   - Counters clear on the start that leaves IDLE.
//   - perf_cycles = counter[perf_sel], registered, 1-cycle latency.
//   - perf_sel out of range 1..NUM_STAGES returns 0.
// T05_SEQ_PERF_EN undefined:
//   - No counters; perf_cycles tied to 0; perf_sel unused.
// TESTING
// 1. Nominal: start, then done one cycle after each stage_start, stages 1..6 ->
//    state 1,2,3,4,5,6,8; finished=1; loop_count=0.
// 2. Loop: at stage 3, loop=1 three times, then plain done -> stage 2 re-entered
//    3 times; stage_start[1] pulses 4 times; loop_count=3; ends in DONE.
// 3. Loop cap: MAX_LOOPS=2, loop requested 3 times -> ERROR on third request;
//    err_code=3; err_stage=3; loop_count=2.
// 4. Watchdog: timeout_limit=10, stage 4 never done -> ERROR after 10 cycles in stage 4;
//    err_code=2; err_stage=4. timeout_limit=0 -> waits forever.
// 5. Priority: in stage 5, done[4] and err[4] same cycle -> ERROR, err_code=1;
//    done[1] while in stage 5 -> ignored. restart -> IDLE, err_* cleared.
// 6. Reset mid-run in stage 2, and PERF check: rst -> IDLE, all outputs 0.
//    With T05_SEQ_PERF_EN: stage 1 held 7 cycles -> perf_sel=1 reads 7.

Source files
------------

// File: rtl/t05_stage_sequencer.sv
// Top-level stage sequencer for the Huffman compression pipeline.
// Steps through NUM_STAGES stages in order. One stage (LOOP_SRC) may send the
// run back to LOOP_DST, up to MAX_LOOPS times. A per-stage watchdog, error
// capture and a restart/abort path are included.
// Optional feature macro: T05_SEQ_PERF_EN adds per-stage cycle counters
// that are read back through perf_sel/perf_cycles.
module t05_stage_sequencer #(
   parameter int NUM_STAGES = 6,
   parameter int STATE_W    = 4,
   parameter int TIMEOUT_W  = 16,
   parameter int LOOP_SRC   = 3,
   parameter int LOOP_DST   = 2,
   parameter int MAX_LOOPS  = 255,
   parameter int LOOP_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  restart,
   input  logic [TIMEOUT_W-1:0]  timeout_limit,
   input  logic [NUM_STAGES-1:0] stage_done,
   input  logic [NUM_STAGES-1:0] stage_loop,
   input  logic [NUM_STAGES-1:0] stage_err,
   output logic [STATE_W-1:0]    state_reg,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic                  finished,
   output logic                  error,
   output logic [STATE_W-1:0]    err_stage,
   output logic [1:0]            err_code,
   output logic [LOOP_W-1:0]     loop_count,
   input  logic [STATE_W-1:0]    perf_sel,
   output logic [31:0]           perf_cycles
);

   localparam logic [STATE_W-1:0] S_IDLE  = '0;
   localparam logic [STATE_W-1:0] S_ERROR = STATE_W'(NUM_STAGES + 1);
   localparam logic [STATE_W-1:0] S_DONE  = STATE_W'(NUM_STAGES + 2);

   localparam logic [1:0] CODE_NONE     = 2'd0;
   localparam logic [1:0] CODE_STAGE    = 2'd1;
   localparam logic [1:0] CODE_TIMEOUT  = 2'd2;
   localparam logic [1:0] CODE_OVERFLOW = 2'd3;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_STAGE,
      PH_ERROR,
      PH_DONE,
      PH_ILLEGAL
   } phase_t;

   phase_t                  phase;
   logic                    cur_done;
   logic                    cur_loop;
   logic                    cur_err;
   logic                    wd_expired;
   logic [TIMEOUT_W-1:0]    wd_cnt;
   logic [STATE_W-1:0]      next_state;
   logic                    enter;
   logic                    err_set;
   logic [1:0]              err_code_n;
   logic [STATE_W-1:0]      err_stage_n;
   logic                    loop_inc;
   logic                    run_clear;
   logic                    abort;
   logic [NUM_STAGES-1:0]   start_vec;

   // Classify the current encoding and pick out the current stage's handshake bits.
   always_comb begin
      phase    = PH_ILLEGAL;
      cur_done = 1'b0;
      cur_loop = 1'b0;
      cur_err  = 1'b0;
      if (state_reg == S_IDLE)
         phase = PH_IDLE;
      else if (state_reg <= STATE_W'(NUM_STAGES))
         phase = PH_STAGE;
      else if (state_reg == S_ERROR)
         phase = PH_ERROR;
      else if (state_reg == S_DONE)
         phase = PH_DONE;
      for (int k = 1; k <= NUM_STAGES; k++) begin
         if (state_reg == STATE_W'(k)) begin
            cur_done = stage_done[k-1];
            cur_loop = stage_loop[k-1];
            cur_err  = stage_err[k-1];
         end
      end
   end

   assign wd_expired = (timeout_limit != '0) &&
                       (wd_cnt == timeout_limit - TIMEOUT_W'(1));

   // Next-state decision: restart beats stage error beats done beats watchdog.
   always_comb begin
      next_state  = state_reg;
      enter       = 1'b0;
      err_set     = 1'b0;
      err_code_n  = CODE_NONE;
      err_stage_n = '0;
      loop_inc    = 1'b0;
      run_clear   = 1'b0;
      abort       = 1'b0;
      start_vec   = '0;
      if (phase == PH_IDLE) begin
         if (start && !restart) begin
            next_state = STATE_W'(1);
            enter      = 1'b1;
            run_clear  = 1'b1;
         end
      end else if (restart) begin
         next_state = S_IDLE;
         abort      = 1'b1;
      end else begin
         case (phase)
            PH_STAGE: begin
               if (cur_err) begin
                  next_state  = S_ERROR;
                  err_set     = 1'b1;
                  err_code_n  = CODE_STAGE;
                  err_stage_n = state_reg;
               end else if (cur_done) begin
                  if (state_reg == STATE_W'(LOOP_SRC) && cur_loop) begin
                     if (loop_count == LOOP_W'(MAX_LOOPS)) begin
                        next_state  = S_ERROR;
                        err_set     = 1'b1;
                        err_code_n  = CODE_OVERFLOW;
                        err_stage_n = state_reg;
                     end else begin
                        next_state = STATE_W'(LOOP_DST);
                        enter      = 1'b1;
                        loop_inc   = 1'b1;
                     end
                  end else if (state_reg == STATE_W'(NUM_STAGES)) begin
                     next_state = S_DONE;
                  end else begin
                     next_state = state_reg + STATE_W'(1);
                     enter      = 1'b1;
                  end
               end else if (wd_expired) begin
                  next_state  = S_ERROR;
                  err_set     = 1'b1;
                  err_code_n  = CODE_TIMEOUT;
                  err_stage_n = state_reg;
               end
            end
            PH_ERROR, PH_DONE: next_state = state_reg;
            default: begin
               next_state  = S_ERROR;
               err_set     = 1'b1;
               err_code_n  = CODE_STAGE;
               err_stage_n = '0;
            end
         endcase
      end
      for (int k = 1; k <= NUM_STAGES; k++)
         start_vec[k-1] = enter && (next_state == STATE_W'(k));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= S_IDLE;
      else
         state_reg <= next_state;
   end

   // Registered status outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_start <= '0;
         finished    <= 1'b0;
         error       <= 1'b0;
      end else begin
         stage_start <= start_vec;
         finished    <= (next_state == S_DONE);
         error       <= (next_state == S_ERROR);
      end
   end

   // Fault capture: cleared when a run starts or is aborted, latched on a fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_code  <= CODE_NONE;
         err_stage <= '0;
      end else if (run_clear || abort) begin
         err_code  <= CODE_NONE;
         err_stage <= '0;
      end else if (err_set) begin
         err_code  <= err_code_n;
         err_stage <= err_stage_n;
      end
   end

   // Loop-back counter for the current run.
   always_ff @(posedge clk) begin
      if (rst || run_clear)
         loop_count <= '0;
      else if (loop_inc)
         loop_count <= loop_count + LOOP_W'(1);
   end

   // Watchdog: restarts on every stage entry, saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst || enter)
         wd_cnt <= '0;
      else if (phase == PH_STAGE && wd_cnt != '1)
         wd_cnt <= wd_cnt + TIMEOUT_W'(1);
   end

`ifdef T05_SEQ_PERF_EN
   logic [31:0] perf_cnt [NUM_STAGES];
   logic [31:0] perf_rd;

   // Select the counter addressed by perf_sel; out-of-range selects read zero.
   always_comb begin
      perf_rd = '0;
      for (int k = 0; k < NUM_STAGES; k++)
         if (perf_sel == STATE_W'(k + 1))
            perf_rd = perf_cnt[k];
   end

   // Saturating per-stage cycle counters, cleared when a run starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_STAGES; k++)
            perf_cnt[k] <= '0;
         perf_cycles <= '0;
      end else begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (run_clear)
               perf_cnt[k] <= '0;
            else if (state_reg == STATE_W'(k + 1) && perf_cnt[k] != '1)
               perf_cnt[k] <= perf_cnt[k] + 32'd1;
         end
         perf_cycles <= perf_rd;
      end
   end
`else
   logic unused_perf_sel;
   assign unused_perf_sel = ^perf_sel;
   assign perf_cycles     = '0;
`endif

endmodule
